dispatch_queue: RTL and testbench
=================================

Name: dispatch_queue

Overview:
- Parametrised, buffered successor of the combinational dispatch stage. Sits between regfile read and the ROB/RS/LSB.
- Holds up to DEPTH renamed instructions in a circular FIFO and snoops the CDB to wake up pending operands while entries wait.
- Dispatches the head entry, in order, when the ROB can allocate a tag and the target unit has room. The target is the RS for ALU/branch ops and the LSB for memory ops.

Parameters:
DEPTH, 4, queue entries; power of 2, >=2
OP_W, 6, opcode width
NICK_W, 4, ROB tag width; tag 0 = "no dependency, value in dt"
DATA_W, 32, operand data width
ADDR_W, 32, pc width
IMM_W, 32, immediate width
NAME_W, 5, architectural register name width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rdy  in  1  global ready; low = freeze
flush  in  1  mispredict flush, synchronous
in_valid  in  1  regfile presents an instruction
in_ready  out  1  queue accepts this cycle
in_op/in_pc/in_imm/in_pd/in_rd_regnm  in  OP_W/ADDR_W/IMM_W/1/NAME_W  instruction fields
in_use_rs1, in_use_rs2  in  1 each  operand used; if 0, nick/dt stored as 0
in_is_mem  in  1  route to LSB (1) or RS (0)
in_rs1_nick, in_rs2_nick  in  NICK_W  source tags
in_rs1_dt, in_rs2_dt  in  DATA_W  source data
cdb_en, cdb_nick, cdb_dt  in  1/NICK_W/DATA_W  result broadcast
rob_nick_en, rob_nick  in  1/NICK_W  ROB free and tag to allocate
rs_full, lsb_full  in  1 each  target back-pressure
out_en, out_to_lsb  out  1 each  dispatch pulse; destination select
out_op, out_pc, out_imm, out_pd, out_rd_regnm, out_rd_nick, out_rs1_nick, out_rs2_nick, out_rs1_dt, out_rs2_dt  out  as inputs  dispatched instruction

Behaviour:
- Reset is asynchronous and active-low. All outputs are registered and cleared to 0 while rst_n=0. Queue count, head and tail pointers are cleared to 0. in_ready=0 during reset.
- in_ready = rdy & !flush & (count != DEPTH), computed combinationally. A push occurs when in_valid & in_ready at a rising edge.
- A push writes the entry at the tail, with two adjustments:
  - an unused operand is stored as nick=0, dt=0;
  - a used operand with nonzero nick matching cdb_nick while cdb_en is high in the same cycle is stored as nick=0, dt=cdb_dt.
- Wakeup: at every edge with rdy=1, each valid entry whose rsX_nick != 0 and == cdb_nick, with cdb_en high, becomes nick=0, dt=cdb_dt. rs1 and rs2 wake independently.
- Pop condition: rdy & !flush & count != 0 & rob_nick_en & !(head.is_mem ? lsb_full : rs_full).
- On a pop:
  - out_* are loaded from the head with same-cycle CDB forwarding applied;
  - out_rd_nick is loaded from rob_nick, out_to_lsb from head.is_mem, and out_en is set to 1;
  - the head pointer advances.
- Without a pop, out_en is 0 on the next cycle and the other out_* fields hold their last values.
- Latency: an instruction pushed into an empty queue at edge E earliest dispatches at edge E+1, so out_en is high during the cycle after E+1. Throughput is one instruction per cycle.
- Push and pop in the same cycle: both take effect and count is unchanged. A push is never accepted when count==DEPTH, even if a pop occurs that cycle.
- Pointers wrap modulo DEPTH. count ranges over 0..DEPTH (log2(DEPTH)+1 bits).
- flush=1 at an edge clears count and pointers and sets out_en to 0. It overrides both push and pop.
- rdy=0: no push, no pop, no wakeup, and out_en is set to 0. All other state holds.
- Dispatch is strictly in order: a blocked head blocks all entries behind it.

Test Plan:
1. Reset then idle: rst_n=0 mid-operation with count=3 -> out_en=0, in_ready=0 immediately; after release, in_ready=1 and count=0.
2. Single ADDI, rs1_nick=0, rs1_dt=5, rob_nick=3, rob_nick_en=1 -> out_en high exactly one cycle, two edges after push; out_rd_nick=3, out_rs1_dt=5, out_rs2_nick=0, out_to_lsb=0.
3. Fill and back-pressure: rob_nick_en=0, push 4 entries (DEPTH=4) -> in_ready=0 on the 5th; raise rob_nick_en -> 4 consecutive out_en pulses in order, in_ready returns to 1 after the first pop.
4. Wakeup: queued entry with rs2_nick=6; cdb_en=1, cdb_nick=6, cdb_dt=0xDEADBEEF -> dispatched out_rs2_nick=0, out_rs2_dt=0xDEADBEEF. Repeat with the CDB hit on the same cycle as the push, and on the same cycle as the pop.
5. Routing: head LW (is_mem=1) with lsb_full=1, rs_full=0 -> no dispatch and the following ADD waits; drop lsb_full -> LW dispatches with out_to_lsb=1, then ADD with out_to_lsb=0.
6. Flush with count=3 while a push and a pop are requested -> next cycle count=0, out_en=0, and the pushed entry is discarded.

Source files
------------

// File: rtl/dispatch_queue_if.sv
// Instruction-in / dispatch-out / CDB / ROB / back-pressure bundle for dispatch_queue.
// slave = queue side, master = regfile/ROB/RS/LSB side.
interface dispatch_queue_if #(
    parameter int OP_W   = 6,
    parameter int NICK_W = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int IMM_W  = 32,
    parameter int NAME_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_op;
    logic [ADDR_W-1:0] in_pc;
    logic [IMM_W-1:0]  in_imm;
    logic              in_pd;
    logic [NAME_W-1:0] in_rd_regnm;
    logic              in_use_rs1;
    logic              in_use_rs2;
    logic              in_is_mem;
    logic [NICK_W-1:0] in_rs1_nick;
    logic [NICK_W-1:0] in_rs2_nick;
    logic [DATA_W-1:0] in_rs1_dt;
    logic [DATA_W-1:0] in_rs2_dt;

    logic              cdb_en;
    logic [NICK_W-1:0] cdb_nick;
    logic [DATA_W-1:0] cdb_dt;
    logic              rob_nick_en;
    logic [NICK_W-1:0] rob_nick;
    logic              rs_full;
    logic              lsb_full;

    logic              out_en;
    logic              out_to_lsb;
    logic [OP_W-1:0]   out_op;
    logic [ADDR_W-1:0] out_pc;
    logic [IMM_W-1:0]  out_imm;
    logic              out_pd;
    logic [NAME_W-1:0] out_rd_regnm;
    logic [NICK_W-1:0] out_rd_nick;
    logic [NICK_W-1:0] out_rs1_nick;
    logic [NICK_W-1:0] out_rs2_nick;
    logic [DATA_W-1:0] out_rs1_dt;
    logic [DATA_W-1:0] out_rs2_dt;

    modport slave (
        input  in_valid, in_op, in_pc, in_imm, in_pd, in_rd_regnm, in_use_rs1, in_use_rs2,
               in_is_mem, in_rs1_nick, in_rs2_nick, in_rs1_dt, in_rs2_dt,
               cdb_en, cdb_nick, cdb_dt, rob_nick_en, rob_nick, rs_full, lsb_full,
        output in_ready, out_en, out_to_lsb, out_op, out_pc, out_imm, out_pd, out_rd_regnm,
               out_rd_nick, out_rs1_nick, out_rs2_nick, out_rs1_dt, out_rs2_dt
    );

    modport master (
        output in_valid, in_op, in_pc, in_imm, in_pd, in_rd_regnm, in_use_rs1, in_use_rs2,
               in_is_mem, in_rs1_nick, in_rs2_nick, in_rs1_dt, in_rs2_dt,
               cdb_en, cdb_nick, cdb_dt, rob_nick_en, rob_nick, rs_full, lsb_full,
        input  in_ready, out_en, out_to_lsb, out_op, out_pc, out_imm, out_pd, out_rd_regnm,
               out_rd_nick, out_rs1_nick, out_rs2_nick, out_rs1_dt, out_rs2_dt
    );
endinterface

// File: rtl/dispatch_queue.sv
// Buffered in-order dispatch queue between regfile read and ROB/RS/LSB.
// Entries snoop the CDB while waiting; head dispatches when ROB tag and target slot are free.

// One queue slot's operand pair (index 0 = rs1, 1 = rs2) with CDB wakeup.
module dq_slot #(
    parameter int NICK_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic                   wake_en,
    input  logic [1:0][NICK_W-1:0] w_nick,
    input  logic [1:0][DATA_W-1:0] w_dt,
    input  logic [NICK_W-1:0]      cdb_nick,
    input  logic [DATA_W-1:0]      cdb_dt,
    output logic [1:0][NICK_W-1:0] nick,
    output logic [1:0][DATA_W-1:0] dt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nick <= '0;
            dt   <= '0;
        end else if (we) begin
            nick <= w_nick;
            dt   <= w_dt;
        end else if (wake_en) begin
            for (int k = 0; k < 2; k++) begin
                if (nick[k] != '0 && nick[k] == cdb_nick) begin
                    nick[k] <= '0;
                    dt[k]   <= cdb_dt;
                end
            end
        end
    end
endmodule

module dispatch_queue #(
    parameter int DEPTH  = 4,
    parameter int OP_W   = 6,
    parameter int NICK_W = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int IMM_W  = 32,
    parameter int NAME_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rdy,
    input  logic            flush,
    dispatch_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] pc;
        logic [IMM_W-1:0]  imm;
        logic              pd;
        logic [NAME_W-1:0] rd_regnm;
        logic              is_mem;
    } meta_t;

    typedef struct packed {
        logic [NICK_W-1:0] nick;
        logic [DATA_W-1:0] dt;
    } opnd_t;

    // Unused operands collapse to 0/0; a same-cycle CDB hit on a pending tag resolves it.
    function automatic opnd_t fwd(input logic used, input logic [NICK_W-1:0] nick,
                                  input logic [DATA_W-1:0] dt, input logic hit_en,
                                  input logic [NICK_W-1:0] hit_nick,
                                  input logic [DATA_W-1:0] hit_dt);
        opnd_t r;
        r.nick = '0;
        r.dt   = '0;
        if (used) begin
            if (hit_en && nick != '0 && nick == hit_nick) begin
                r.dt = hit_dt;
            end else begin
                r.nick = nick;
                r.dt   = dt;
            end
        end
        return r;
    endfunction

    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] head, tail;
    logic             full, empty, push, pop, head_blocked;

    meta_t meta_q [DEPTH];
    meta_t push_meta, head_meta;
    opnd_t push_rs1, push_rs2, pop_rs1, pop_rs2;

    logic [DEPTH-1:0]                   slot_valid;
    logic [DEPTH-1:0][1:0][NICK_W-1:0]  slot_nick;
    logic [DEPTH-1:0][1:0][DATA_W-1:0]  slot_dt;
    logic [1:0][NICK_W-1:0]             push_nick;
    logic [1:0][DATA_W-1:0]             push_dt;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    assign bus.in_ready = rst_n & rdy & ~flush & ~full;
    assign push         = bus.in_valid & bus.in_ready;

    assign head_meta    = meta_q[head];
    assign head_blocked = head_meta.is_mem ? bus.lsb_full : bus.rs_full;
    assign pop          = rdy & ~flush & ~empty & bus.rob_nick_en & ~head_blocked;

    assign push_meta = '{op: bus.in_op, pc: bus.in_pc, imm: bus.in_imm, pd: bus.in_pd,
                         rd_regnm: bus.in_rd_regnm, is_mem: bus.in_is_mem};

    assign push_rs1  = fwd(bus.in_use_rs1, bus.in_rs1_nick, bus.in_rs1_dt,
                           bus.cdb_en, bus.cdb_nick, bus.cdb_dt);
    assign push_rs2  = fwd(bus.in_use_rs2, bus.in_rs2_nick, bus.in_rs2_dt,
                           bus.cdb_en, bus.cdb_nick, bus.cdb_dt);
    assign push_nick = {push_rs2.nick, push_rs1.nick};
    assign push_dt   = {push_rs2.dt, push_rs1.dt};

    // Stored operands are already normalised, so the head is forwarded as "used".
    assign pop_rs1 = fwd(1'b1, slot_nick[head][0], slot_dt[head][0],
                         bus.cdb_en, bus.cdb_nick, bus.cdb_dt);
    assign pop_rs2 = fwd(1'b1, slot_nick[head][1], slot_dt[head][1],
                         bus.cdb_en, bus.cdb_nick, bus.cdb_dt);

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [PTR_W-1:0] off;
        // Slot i is occupied when its distance from head is below count.
        assign off           = PTR_W'(i) - head;
        assign slot_valid[i] = ({1'b0, off} < count);

        dq_slot #(.NICK_W(NICK_W), .DATA_W(DATA_W)) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .we       (push && (tail == PTR_W'(i))),
            .wake_en  (rdy & bus.cdb_en & slot_valid[i]),
            .w_nick   (push_nick),
            .w_dt     (push_dt),
            .cdb_nick (bus.cdb_nick),
            .cdb_dt   (bus.cdb_dt),
            .nick     (slot_nick[i]),
            .dt       (slot_dt[i])
        );
    end

    always_ff @(posedge clk) begin
        if (push) meta_q[tail] <= push_meta;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else if (flush) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_en       <= 1'b0;
            bus.out_to_lsb   <= 1'b0;
            bus.out_op       <= '0;
            bus.out_pc       <= '0;
            bus.out_imm      <= '0;
            bus.out_pd       <= 1'b0;
            bus.out_rd_regnm <= '0;
            bus.out_rd_nick  <= '0;
            bus.out_rs1_nick <= '0;
            bus.out_rs2_nick <= '0;
            bus.out_rs1_dt   <= '0;
            bus.out_rs2_dt   <= '0;
        end else if (pop) begin
            bus.out_en       <= 1'b1;
            bus.out_to_lsb   <= head_meta.is_mem;
            bus.out_op       <= head_meta.op;
            bus.out_pc       <= head_meta.pc;
            bus.out_imm      <= head_meta.imm;
            bus.out_pd       <= head_meta.pd;
            bus.out_rd_regnm <= head_meta.rd_regnm;
            bus.out_rd_nick  <= bus.rob_nick;
            bus.out_rs1_nick <= pop_rs1.nick;
            bus.out_rs2_nick <= pop_rs2.nick;
            bus.out_rs1_dt   <= pop_rs1.dt;
            bus.out_rs2_dt   <= pop_rs2.dt;
        end else begin
            bus.out_en <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue: reset, latency, fill/back-pressure, wakeup,
// routing, flush and freeze.
module tb_dispatch_queue;
    localparam int DEPTH = 4, OP_W = 6, NICK_W = 4, DATA_W = 32, ADDR_W = 32, IMM_W = 32, NAME_W = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rdy = 1'b0;
    logic flush = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dispatch_queue_if #(.OP_W(OP_W), .NICK_W(NICK_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
                        .IMM_W(IMM_W), .NAME_W(NAME_W)) bus ();

    dispatch_queue #(.DEPTH(DEPTH), .OP_W(OP_W), .NICK_W(NICK_W), .DATA_W(DATA_W),
                     .ADDR_W(ADDR_W), .IMM_W(IMM_W), .NAME_W(NAME_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rdy   (rdy),
        .flush (flush),
        .bus   (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rdy = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_pc = '0; bus.in_imm = '0; bus.in_pd = 1'b0;
        bus.in_rd_regnm = '0; bus.in_use_rs1 = 1'b0; bus.in_use_rs2 = 1'b0; bus.in_is_mem = 1'b0;
        bus.in_rs1_nick = '0; bus.in_rs2_nick = '0; bus.in_rs1_dt = '0; bus.in_rs2_dt = '0;
        bus.cdb_en = 1'b0; bus.cdb_nick = '0; bus.cdb_dt = '0;
        bus.rob_nick_en = 1'b0; bus.rob_nick = '0; bus.rs_full = 1'b0; bus.lsb_full = 1'b0;
    endtask

    task automatic push_set(input logic [5:0] op, input logic [31:0] pc, input logic is_mem,
                            input logic u1, input logic [3:0] n1, input logic [31:0] d1,
                            input logic u2, input logic [3:0] n2, input logic [31:0] d2);
        bus.in_valid = 1'b1; bus.in_op = op; bus.in_pc = pc; bus.in_imm = pc + 32'd1;
        bus.in_pd = 1'b1; bus.in_rd_regnm = op[4:0]; bus.in_is_mem = is_mem;
        bus.in_use_rs1 = u1; bus.in_rs1_nick = n1; bus.in_rs1_dt = d1;
        bus.in_use_rs2 = u2; bus.in_rs2_nick = n2; bus.in_rs2_dt = d2;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        tick(); tick();
        checks++; if (bus.out_en !== 1'b0) begin errors++; $display("FAIL rst_out_en: got %b exp 0", bus.out_en); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b exp 0", bus.in_ready); end
        rst_n = 1'b1; #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready: got %b exp 1", bus.in_ready); end
        for (int i = 0; i < 4; i++) begin
            push_set(6'(i + 1), 32'h40 + 32'(i), 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
            tick();
        end
        bus.in_valid = 1'b0; bus.rob_nick_en = 1'b1; bus.rob_nick = 4'd1;
        tick();
        bus.rob_nick_en = 1'b0;
        checks++; if (bus.out_en !== 1'b1) begin errors++; $display("FAIL pre_rst_pop: got %b exp 1", bus.out_en); end
        checks++; if (dut.count !== 3'd3) begin errors++; $display("FAIL pre_rst_count: got %0d exp 3", dut.count); end
        #2 rst_n = 1'b0; #1;
        checks++; if (bus.out_en !== 1'b0) begin errors++; $display("FAIL async_rst_out_en: got %b exp 0", bus.out_en); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL async_rst_in_ready: got %b exp 0", bus.in_ready); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b exp 1", bus.in_ready); end
        checks++; if (dut.count !== 3'd0) begin errors++; $display("FAIL post_rst_count: got %0d exp 0", dut.count); end
    endtask

    task automatic test_single();
        idle();
        bus.rob_nick_en = 1'b1; bus.rob_nick = 4'd3;
        push_set(6'h13, 32'h100, 1'b0, 1'b1, 4'd0, 32'd5, 1'b0, 4'h9, 32'h55);
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_en !== 1'b0) begin errors++; $display("FAIL single_early: got %b exp 0", bus.out_en); end
        tick();
        checks++; if (bus.out_en !== 1'b1) begin errors++; $display("FAIL single_out_en: got %b exp 1", bus.out_en); end
        checks++; if (bus.out_rd_nick !== 4'd3) begin errors++; $display("FAIL single_rd_nick: got %0d exp 3", bus.out_rd_nick); end
        checks++; if (bus.out_rs1_dt !== 32'd5 || bus.out_rs1_nick !== 4'd0) begin errors++; $display("FAIL single_rs1: got %0d/%h exp 0/5", bus.out_rs1_nick, bus.out_rs1_dt); end
        checks++; if (bus.out_rs2_nick !== 4'd0 || bus.out_rs2_dt !== 32'd0) begin errors++; $display("FAIL single_rs2_unused: got %0d/%h exp 0/0", bus.out_rs2_nick, bus.out_rs2_dt); end
        checks++; if (bus.out_to_lsb !== 1'b0) begin errors++; $display("FAIL single_to_lsb: got %b exp 0", bus.out_to_lsb); end
        checks++; if (bus.out_op !== 6'h13 || bus.out_pc !== 32'h100 || bus.out_imm !== 32'h101) begin errors++; $display("FAIL single_fields: got %h %h %h exp 13 100 101", bus.out_op, bus.out_pc, bus.out_imm); end
        tick();
        checks++; if (bus.out_en !== 1'b0) begin errors++; $display("FAIL single_one_pulse: got %b exp 0", bus.out_en); end
    endtask

    task automatic test_back_to_back();
        idle();
        for (int i = 0; i < 4; i++) begin
            push_set(6'(i + 1), 32'h200 + 32'(4 * i), 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
            #1;
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d: got %b exp 1", i, bus.in_ready); end
            tick();
        end
        push_set(6'h09, 32'h210, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b exp 0", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0; bus.rob_nick_en = 1'b1; bus.rob_nick = 4'd5;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.out_en !== 1'b1 || bus.out_op !== 6'(i + 1) || bus.out_pc !== 32'h200 + 32'(4 * i)) begin
                errors++; $display("FAIL drain_%0d: got en=%b op=%h pc=%h exp en=1 op=%h", i, bus.out_en, bus.out_op, bus.out_pc, i + 1);
            end
            if (i == 0) begin
                checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_pop: got %b exp 1", bus.in_ready); end
            end
        end
        tick();
        checks++; if (bus.out_en !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b exp 0", bus.out_en); end
    endtask

    task automatic test_wakeup();
        // wakeup while queued; rs1 tag 7 must stay pending
        idle();
        push_set(6'h20, 32'h300, 1'b0, 1'b1, 4'd7, 32'd0, 1'b1, 4'd6, 32'd0);
        tick();
        bus.in_valid = 1'b0; bus.cdb_en = 1'b1; bus.cdb_nick = 4'd6; bus.cdb_dt = 32'hDEADBEEF;
        tick();
        bus.cdb_en = 1'b0; bus.rob_nick_en = 1'b1; bus.rob_nick = 4'd2;
        tick();
        checks++; if (bus.out_en !== 1'b1 || bus.out_rs2_nick !== 4'd0 || bus.out_rs2_dt !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wake_queued: got en=%b nick=%0d dt=%h exp 1/0/deadbeef", bus.out_en, bus.out_rs2_nick, bus.out_rs2_dt);
        end
        checks++; if (bus.out_rs1_nick !== 4'd7) begin errors++; $display("FAIL wake_indep: got %0d exp 7", bus.out_rs1_nick); end
        // CDB hit in the push cycle
        idle();
        push_set(6'h21, 32'h304, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'd0);
        bus.cdb_en = 1'b1; bus.cdb_nick = 4'd6; bus.cdb_dt = 32'hCAFEF00D;
        tick();
        bus.in_valid = 1'b0; bus.cdb_en = 1'b0; bus.rob_nick_en = 1'b1; bus.rob_nick = 4'd4;
        tick();
        checks++; if (bus.out_en !== 1'b1 || bus.out_rs2_nick !== 4'd0 || bus.out_rs2_dt !== 32'hCAFEF00D) begin
            errors++; $display("FAIL wake_push: got en=%b nick=%0d dt=%h exp 1/0/cafef00d", bus.out_en, bus.out_rs2_nick, bus.out_rs2_dt);
        end
        // CDB hit in the pop cycle
        idle();
        push_set(6'h22, 32'h308, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'd0);
        tick();
        bus.in_valid = 1'b0; bus.rob_nick_en = 1'b1; bus.rob_nick = 4'd8;
        bus.cdb_en = 1'b1; bus.cdb_nick = 4'd6; bus.cdb_dt = 32'h12345678;
        tick();
        bus.cdb_en = 1'b0;
        checks++; if (bus.out_en !== 1'b1 || bus.out_rs2_nick !== 4'd0 || bus.out_rs2_dt !== 32'h12345678) begin
            errors++; $display("FAIL wake_pop: got en=%b nick=%0d dt=%h exp 1/0/12345678", bus.out_en, bus.out_rs2_nick, bus.out_rs2_dt);
        end
        tick();
    endtask

    task automatic test_routing();
        idle();
        push_set(6'h03, 32'h400, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        tick();
        push_set(6'h33, 32'h404, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        tick();
        bus.in_valid = 1'b0; bus.rob_nick_en = 1'b1; bus.rob_nick = 4'd9; bus.lsb_full = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (bus.out_en !== 1'b0) begin errors++; $display("FAIL route_blocked_%0d: got %b exp 0", i, bus.out_en); end
        end
        bus.lsb_full = 1'b0;
        tick();
        checks++; if (bus.out_en !== 1'b1 || bus.out_to_lsb !== 1'b1 || bus.out_op !== 6'h03) begin
            errors++; $display("FAIL route_lw: got en=%b lsb=%b op=%h exp 1/1/03", bus.out_en, bus.out_to_lsb, bus.out_op);
        end
        tick();
        checks++; if (bus.out_en !== 1'b1 || bus.out_to_lsb !== 1'b0 || bus.out_op !== 6'h33) begin
            errors++; $display("FAIL route_add: got en=%b lsb=%b op=%h exp 1/0/33", bus.out_en, bus.out_to_lsb, bus.out_op);
        end
        tick();
    endtask

    task automatic test_flush();
        idle();
        for (int i = 0; i < 3; i++) begin
            push_set(6'(i + 16), 32'h500 + 32'(i), 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
            tick();
        end
        push_set(6'h3F, 32'h5FF, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        bus.rob_nick_en = 1'b1; bus.rob_nick = 4'd10; flush = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b exp 0", bus.in_ready); end
        tick();
        flush = 1'b0; bus.in_valid = 1'b0; bus.rob_nick_en = 1'b0;
        checks++; if (bus.out_en !== 1'b0) begin errors++; $display("FAIL flush_out_en: got %b exp 0", bus.out_en); end
        checks++; if (dut.count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d exp 0", dut.count); end
        bus.rob_nick_en = 1'b1;
        tick();
        checks++; if (bus.out_en !== 1'b0) begin errors++; $display("FAIL flush_discard: got %b exp 0", bus.out_en); end
    endtask

    task automatic test_freeze();
        idle();
        push_set(6'h23, 32'h600, 1'b0, 1'b1, 4'd5, 32'd0, 1'b0, 4'd0, 32'd0);
        tick();
        bus.in_valid = 1'b0; rdy = 1'b0; bus.rob_nick_en = 1'b1; bus.rob_nick = 4'd11;
        bus.cdb_en = 1'b1; bus.cdb_nick = 4'd5; bus.cdb_dt = 32'hAA;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL freeze_ready: got %b exp 0", bus.in_ready); end
        tick();
        checks++; if (bus.out_en !== 1'b0) begin errors++; $display("FAIL freeze_no_pop: got %b exp 0", bus.out_en); end
        rdy = 1'b1; bus.cdb_en = 1'b0;
        tick();
        checks++; if (bus.out_en !== 1'b1 || bus.out_rs1_nick !== 4'd5 || bus.out_rd_nick !== 4'd11) begin
            errors++; $display("FAIL freeze_no_wake: got en=%b nick=%0d rd=%0d exp 1/5/11", bus.out_en, bus.out_rs1_nick, bus.out_rd_nick);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_wakeup();
        test_routing();
        test_flush();
        test_freeze();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
